dense_argmax: RTL and testbench

- Classifier output stage, directly downstream of the dense layer.
- Captures the dense layer's post-ReLU vector of CLASSES IEEE-754 single-precision scores in one handshake.
- Scans the scores serially, one per cycle, with a single float comparator.
- Returns the index and value of the maximum score on a valid/ready output handshake.

---
 rtl/dense_argmax.sv | 77 +++++++
 tb/tb_dense_argmax.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/dense_argmax.sv
// dense_argmax: serial float32 argmax over a captured score vector with valid/ready handshakes
module dense_argmax #(
  parameter int DATA_WIDTH = 32,
  parameter int CLASSES = 7,
  localparam int IDX_W = CLASSES > 1 ? $clog2(CLASSES) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH*CLASSES-1:0] data_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  output logic [IDX_W-1:0]              class_o,
  output logic [DATA_WIDTH-1:0]         max_o,
  output logic                          valid_o,
  input  logic                          ready_i
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(CLASSES - 1);
  state_t state, next;
  logic [DATA_WIDTH*CLASSES-1:0] data_r;
  logic [DATA_WIDTH-1:0] best_val, cur;
  logic [IDX_W-1:0] best_idx, idx;
  logic upd, last;
  function automatic logic gt(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
    logic a_nan, b_nan;
    a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    if (a_nan) return 1'b0;
    if (b_nan) return 1'b1;
    if (a[30:0] == 0 && b[30:0] == 0) return 1'b0;
    if (a[31] != b[31]) return b[31];
    return a[31] ? (a[30:0] < b[30:0]) : (a[30:0] > b[30:0]);
  endfunction
  assign ready_o = (state == IDLE) && !rst;
  assign valid_o = (state == DONE);
  assign cur = data_r[idx*DATA_WIDTH +: DATA_WIDTH];
  assign upd = gt(cur, best_val);
  assign last = (idx == LAST);
  always_comb begin
    next = state;
    if (state == IDLE) next = valid_i ? (CLASSES == 1 ? DONE : SCAN) : IDLE;
    else if (state == SCAN) next = last ? DONE : SCAN;
    else next = ready_i ? IDLE : DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= next;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r <= '0;
      best_val <= '0;
      best_idx <= '0;
      idx <= '0;
      class_o <= '0;
      max_o <= '0;
    end else if (state == IDLE && valid_i) begin
      data_r <= data_i;
      best_val <= data_i[DATA_WIDTH-1:0];
      best_idx <= '0;
      idx <= IDX_W'(1);
      if (CLASSES == 1) begin
        class_o <= '0;
        max_o <= data_i[DATA_WIDTH-1:0];
      end
    end else if (state == SCAN) begin
      best_val <= upd ? cur : best_val;
      best_idx <= upd ? idx : best_idx;
      idx <= idx + 1'b1;
      // publish only when the scan finishes so outputs stay put until then
      if (last) begin
        class_o <= upd ? idx : best_idx;
        max_o <= upd ? cur : best_val;
      end
    end
  end
endmodule

// File: tb/tb_dense_argmax.sv
// tb_dense_argmax: directed scoreboard bench for dense_argmax
module tb_dense_argmax;
  localparam int DW = 32;
  localparam int CL = 7;
  localparam int IW = 3;
  localparam int W = DW * CL;
  typedef struct packed {logic [IW-1:0] c; logic [DW-1:0] m;} exp_t;
  logic clk = 0, rst = 1, valid_i = 0, ready_i = 0, ready_o, valid_o;
  logic [W-1:0] data_i = '0;
  logic [IW-1:0] class_o;
  logic [DW-1:0] max_o;
  int errors = 0, checks = 0;
  exp_t sb[$];
  exp_t cur;
  int n;
  dense_argmax #(.DATA_WIDTH(DW), .CLASSES(CL)) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
    .class_o(class_o), .max_o(max_o), .valid_o(valid_o), .ready_i(ready_i)
  );
  always #5 clk = ~clk;
  function automatic logic [W-1:0] vec(input logic [31:0] e0, e1, e2, e3, e4, e5, e6);
    return {e6, e5, e4, e3, e2, e1, e0};
  endfunction
  function automatic logic [W-1:0] rnd();
    logic [W-1:0] r;
    for (int i = 0; i < CL; i++) r[i*DW +: DW] = $urandom;
    return r;
  endfunction
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic take();
    chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
    cur = sb.size() != 0 ? sb.pop_front() : '0;
    chk("class", 64'(class_o), 64'(cur.c));
    chk("max", 64'(max_o), 64'(cur.m));
  endtask
  task automatic run(input logic [W-1:0] v, input logic [IW-1:0] c, input logic [DW-1:0] m, input int hold);
    @(negedge clk);
    chk("ready_idle", 64'(ready_o), 64'd1);
    data_i = v;
    valid_i = 1;
    sb.push_back('{c, m});
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!valid_o) chk("ready_scan", 64'(ready_o), 64'd0);
      valid_i = 1'($urandom_range(0, 1));
      data_i = rnd();
    end while (!valid_o && n < 50);
    chk("latency", 64'(n), 64'd7);
    take();
    repeat (hold) begin
      @(negedge clk);
      valid_i = 1'($urandom_range(0, 1));
      data_i = rnd();
      chk("hold_valid", 64'(valid_o), 64'd1);
      chk("hold_class", 64'(class_o), 64'(cur.c));
      chk("hold_max", 64'(max_o), 64'(cur.m));
      chk("hold_ready", 64'(ready_o), 64'd0);
    end
    ready_i = 1;
    @(negedge clk);
    chk("handoff_valid", 64'(valid_o), 64'd0);
    chk("handoff_ready", 64'(ready_o), 64'd1);
    ready_i = 0;
    valid_i = 0;
  endtask
  initial begin
    logic [W-1:0] v1, v2, v3, v4, v5, v6, v7;
    v1 = vec(32'h3F000000, 32'h3F800000, 32'h40000000, 32'h3F800000, 0, 0, 0);
    v2 = vec(32'h3F800000, 32'h3F800000, 0, 0, 0, 0, 0);
    v3 = vec(32'h80000000, 32'h00000000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000);
    v4 = vec(32'hBF800000, 32'hC0000000, 32'h7FC00000, 32'hBF000000, 32'hFF800000, 32'hBF800000, 32'hC0400000);
    v5 = vec(32'hBF800000, 32'hC0000000, 32'h7FC00000, 32'hBF000000, 32'hFF800000, 32'hBF800000, 32'h7F800000);
    v6 = {CL{32'h7FC00000}};
    v7 = vec(32'h7FC00000, 32'hBF800000, 32'hFF800000, 32'hFF800000, 32'hFF800000, 32'hFF800000, 32'hFF800000);
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(ready_o), 64'd0);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_class", 64'(class_o), 64'd0);
    chk("rst_max", 64'(max_o), 64'd0);
    rst = 0;
    @(negedge clk);
    chk("post_rst_ready", 64'(ready_o), 64'd1);
    run(v1, 3'd2, 32'h40000000, 0);
    run(v2, 3'd0, 32'h3F800000, 0);
    run(v3, 3'd0, 32'h80000000, 0);
    run(v4, 3'd3, 32'hBF000000, 10);
    run(v5, 3'd6, 32'h7F800000, 0);
    run(v6, 3'd0, 32'h7FC00000, 0);
    run(v7, 3'd1, 32'hBF800000, 2);
    // back-to-back with valid_i and ready_i held high
    @(negedge clk);
    ready_i = 1;
    valid_i = 1;
    data_i = v1;
    sb.push_back('{3'd2, 32'h40000000});
    n = 0;
    do begin @(negedge clk); n++; end while (!valid_o && n < 50);
    chk("b2b_lat_a", 64'(n), 64'd7);
    take();
    data_i = v5;
    sb.push_back('{3'd6, 32'h7F800000});
    @(negedge clk);
    chk("b2b_gap_valid", 64'(valid_o), 64'd0);
    chk("b2b_gap_ready", 64'(ready_o), 64'd1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) chk("b2b_accepted", 64'(ready_o), 64'd0);
    end while (!valid_o && n < 50);
    chk("b2b_lat_b", 64'(n), 64'd7);
    take();
    valid_i = 0;
    @(negedge clk);
    ready_i = 0;
    chk("b2b_done_valid", 64'(valid_o), 64'd0);
    // reset in the middle of a scan aborts it
    @(negedge clk);
    data_i = v4;
    valid_i = 1;
    @(negedge clk);
    valid_i = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    #1 chk("midrst_ready", 64'(ready_o), 64'd0);
    @(negedge clk);
    rst = 0;
    #1;
    chk("abort_ready", 64'(ready_o), 64'd1);
    chk("abort_valid", 64'(valid_o), 64'd0);
    chk("abort_class", 64'(class_o), 64'd0);
    chk("abort_max", 64'(max_o), 64'd0);
    n = 0;
    repeat (10) begin @(negedge clk); n += int'(valid_o); end
    chk("abort_no_result", 64'(n), 64'd0);
    run(v4, 3'd3, 32'hBF000000, 1);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
